usr_seq_shifter: RTL

// - Parametrised successor to the single-step universal shift register: accepts one command
//   per valid/ready handshake and executes multi-step shift, rotate and arithmetic operations.
// - Executes one bit-step per clock on a WIDTH-bit register. Reports the bit shifted out,

---
 rtl/usr_seq_pkg.sv | 59 +++++
 rtl/usr_seq_step.sv | 27 ++
 rtl/usr_seq_shifter.sv | 119 +++++++++++
 3 files changed

// File: rtl/usr_seq_pkg.sv
// Shared definitions for the sequenced universal shifter: op codes, FSM states, one-step helper.
// The optional abort feature is enabled by defining USR_SEQ_ABORT_EN.
package usr_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  // Widest register the step helper supports; callers zero-extend into this width.
  localparam int USR_MAX_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_t;

  function automatic logic usr_is_step(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_CLR);
  endfunction

  // One bit-step on the low w bits of q; returns {out_bit, q_next}.
  function automatic logic [USR_MAX_W:0] usr_step(input logic [USR_MAX_W-1:0] q,
                                                  input int w,
                                                  input logic [2:0] op,
                                                  input logic fill);
    logic [USR_MAX_W-1:0] mask;
    logic [USR_MAX_W-1:0] msb_pos;
    logic [USR_MAX_W-1:0] qr;
    logic [USR_MAX_W-1:0] ql;
    logic [USR_MAX_W-1:0] nxt;
    logic msb;
    logic lsb;
    logic ob;
    mask = '0;
    for (int i = 0; i < USR_MAX_W; i++) mask[i] = (i < w);
    msb_pos = USR_MAX_W'(1) << (w - 1);
    msb = |(q & msb_pos);
    lsb = q[0];
    qr  = q >> 1;
    ql  = (q << 1) & mask;
    nxt = q;
    ob  = 1'b0;
    case (op)
      OP_SHR: begin nxt = qr | (fill ? msb_pos : '0); ob = lsb; end
      OP_SHL: begin nxt = ql | USR_MAX_W'(fill);      ob = msb; end
      OP_ROR: begin nxt = qr | (lsb ? msb_pos : '0);  ob = lsb; end
      OP_ROL: begin nxt = ql | USR_MAX_W'(msb);       ob = msb; end
      OP_ASR: begin nxt = qr | (msb ? msb_pos : '0);  ob = lsb; end
      default: begin nxt = q; ob = 1'b0; end
    endcase
    return {ob, nxt};
  endfunction

endpackage

// File: rtl/usr_seq_step.sv
// Combinational single bit-step of the shifter for every op code.
module usr_seq_step
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  logic [USR_MAX_W:0] res;

  assign res     = usr_step(USR_MAX_W'(q), WIDTH, op, serial_in);
  assign q_next  = res[WIDTH-1:0];
  assign out_bit = res[USR_MAX_W];

  generate
    if (WIDTH < USR_MAX_W) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^res[USR_MAX_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/usr_seq_shifter.sv
// Multi-step universal shift register with valid/ready command interface.
// Define USR_SEQ_ABORT_EN to add the abort/aborted ports.
module usr_seq_shifter
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
`ifdef USR_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  usr_state_t       state_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] q_reg;
  logic             so_reg;
  logic             done_reg;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_out;
`ifdef USR_SEQ_ABORT_EN
  logic             aborted_reg;
`endif

  // The accept edge already performs step 1, so the stepper sees the live op in IDLE.
  assign step_op = (state_reg == ST_RUN) ? op_reg : cmd_op;

  usr_seq_step #(.WIDTH(WIDTH)) u_step (
    .q         (q_reg),
    .op        (step_op),
    .serial_in (serial_in),
    .q_next    (step_q),
    .out_bit   (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rem_reg     <= '0;
      op_reg      <= OP_NOP;
      q_reg       <= '0;
      so_reg      <= 1'b0;
      done_reg    <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
      aborted_reg <= 1'b0;
`endif
    end else begin
      done_reg    <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
      aborted_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (usr_is_step(cmd_op) && (cmd_count != '0)) begin
              q_reg  <= step_q;
              so_reg <= step_out;
              if (cmd_count == CNT_W'(1)) begin
                done_reg <= 1'b1;
              end else begin
                state_reg <= ST_RUN;
                rem_reg   <= cmd_count - CNT_W'(1);
                op_reg    <= cmd_op;
              end
            end else begin
              done_reg <= 1'b1;
              if (cmd_op == OP_LOAD) q_reg <= parallel_in;
              else if (cmd_op == OP_CLR) q_reg <= '0;
            end
          end
        end
        ST_RUN: begin
`ifdef USR_SEQ_ABORT_EN
          if (abort) begin
            state_reg   <= ST_IDLE;
            aborted_reg <= 1'b1;
          end else
`endif
          begin
            q_reg   <= step_q;
            so_reg  <= step_out;
            rem_reg <= rem_reg - CNT_W'(1);
            if (rem_reg == CNT_W'(1)) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg == ST_RUN);
  assign q          = q_reg;
  assign serial_out = so_reg;
  assign done       = done_reg;
`ifdef USR_SEQ_ABORT_EN
  assign aborted    = aborted_reg;
`endif

endmodule
